// File: rtl/irq_pkg.sv
// Shared constants, source-to-group map and FSM state type for the interrupt controller.
// Register map: PRI at IRQ_PRI_BASE (3 bytes), ENA at IRQ_ENA_BASE (4 bytes),
// ACT at IRQ_ACT_BASE (4 bytes).
package irq_pkg;

    localparam int unsigned MAX_IRQS     = 32;
    localparam int unsigned NUM_GROUPS   = 12;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned PRI_W        = 2;
    localparam int unsigned ADDR_W       = 24;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned NUM_PRI_REGS = 3;
    localparam int unsigned NUM_SRC_REGS = 4;

    localparam logic [ADDR_W-1:0] IRQ_PRI_BASE = 24'h2020;
    localparam logic [ADDR_W-1:0] IRQ_ENA_BASE = 24'h2023;
    localparam logic [ADDR_W-1:0] IRQ_ACT_BASE = 24'h2027;
    localparam logic [7:0]        VECTOR_BASE  = 8'h03;

    // Source i belongs to priority group IRQ_GROUP[i]; groups cycle round the 12 slots.
    localparam logic [3:0] IRQ_GROUP [MAX_IRQS] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7
    };

    typedef enum logic {
        IDLE    = 1'b0,
        REQUEST = 1'b1
    } irq_state_t;

endpackage

// File: rtl/irq_if.sv
// System-bus register access port of the interrupt controller.
// master: bus driver (write/read strobes, address, write data); slave: controller (read data).
interface irq_if;

    logic                         bus_write;
    logic                         bus_read;
    logic [irq_pkg::ADDR_W-1:0]   bus_address_in;
    logic [irq_pkg::DATA_W-1:0]   bus_data_in;
    logic [irq_pkg::DATA_W-1:0]   bus_data_out;

    modport master (
        output bus_write, bus_read, bus_address_in, bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  bus_write, bus_read, bus_address_in, bus_data_in,
        output bus_data_out
    );

endinterface

// File: rtl/irq_arbiter.sv
// Combinational pick among eligible sources: highest priority wins, ties to the lowest index.
// Ports: elig (eligible vector), src_pri (per-source priority) -> valid, index, pri.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N = MAX_IRQS
) (
    input  logic [N-1:0]            elig,
    input  logic [N-1:0][PRI_W-1:0] src_pri,
    output logic                    valid,
    output logic [IDX_W-1:0]        index,
    output logic [PRI_W-1:0]        pri
);

    // Scan downwards so an equal-priority lower index replaces the current pick.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pri   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (elig[i] && (!valid || src_pri[i] >= pri)) begin
                valid = 1'b1;
                index = IDX_W'(i);
                pri   = src_pri[i];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches peripheral pulses into flags, applies enables and group
// priorities, arbitrates against cpu_mask and presents one registered request with ack.
// Ports: clk, reset (sync, active-high), clk_ce_cpu, bus (register access), irq_in,
// cpu_mask, irq_ack -> irq_req, irq_vector, irq_pri.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQS = MAX_IRQS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce_cpu,
    irq_if.slave                bus,
    input  logic [NUM_IRQS-1:0] irq_in,
    input  logic [PRI_W-1:0]    cpu_mask,
    input  logic                irq_ack,
    output logic                irq_req,
    output logic [7:0]          irq_vector,
    output logic [PRI_W-1:0]    irq_pri
);

    // Bits for sources that do not exist stay zero and ignore writes.
    localparam logic [MAX_IRQS-1:0] SRC_MASK = MAX_IRQS'((64'(1) << NUM_IRQS) - 64'(1));

    logic [NUM_GROUPS*PRI_W-1:0]    pri_q, pri_d;
    logic [MAX_IRQS-1:0]            ena_q, ena_d;
    logic [MAX_IRQS-1:0]            flag_q, flag_d;
    logic [MAX_IRQS-1:0]            insvc_q, insvc_d;
    logic [MAX_IRQS-1:0]            act_clr, ack_set, elig;
    logic [MAX_IRQS-1:0][PRI_W-1:0] src_pri;

    irq_state_t       state_q, state_d;
    logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
    logic             req_d;
    logic [7:0]       vec_d;
    logic [PRI_W-1:0] pri_out_d;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [PRI_W-1:0] arb_pri;

    // Register writes, flag set/clear (set wins) and in-service bookkeeping.
    always_comb begin
        pri_d   = pri_q;
        ena_d   = ena_q;
        act_clr = '0;
        if (bus.bus_write) begin
            for (int k = 0; k < int'(NUM_PRI_REGS); k++) begin
                if (bus.bus_address_in == IRQ_PRI_BASE + ADDR_W'(k)) pri_d[8*k +: 8] = bus.bus_data_in;
            end
            for (int b = 0; b < int'(NUM_SRC_REGS); b++) begin
                if (bus.bus_address_in == IRQ_ENA_BASE + ADDR_W'(b)) ena_d[8*b +: 8] = bus.bus_data_in;
                if (bus.bus_address_in == IRQ_ACT_BASE + ADDR_W'(b)) act_clr[8*b +: 8] = bus.bus_data_in;
            end
        end
        ena_d   = ena_d & SRC_MASK;
        flag_d  = ((flag_q & ~act_clr) | MAX_IRQS'(irq_in)) & SRC_MASK;
        insvc_d = (insvc_q | ack_set) & flag_d;
    end

    // Raw register read-back; zero when not reading or unmapped.
    always_comb begin
        bus.bus_data_out = '0;
        if (bus.bus_read) begin
            for (int k = 0; k < int'(NUM_PRI_REGS); k++) begin
                if (bus.bus_address_in == IRQ_PRI_BASE + ADDR_W'(k)) bus.bus_data_out = pri_q[8*k +: 8];
            end
            for (int b = 0; b < int'(NUM_SRC_REGS); b++) begin
                if (bus.bus_address_in == IRQ_ENA_BASE + ADDR_W'(b)) bus.bus_data_out = ena_q[8*b +: 8];
                if (bus.bus_address_in == IRQ_ACT_BASE + ADDR_W'(b)) bus.bus_data_out = flag_q[8*b +: 8];
            end
        end
    end

    // Per-source priority from its group and the eligibility vector.
    always_comb begin
        for (int i = 0; i < int'(MAX_IRQS); i++) begin
            src_pri[i] = pri_q[PRI_W*int'(IRQ_GROUP[i]) +: PRI_W];
            elig[i]    = flag_q[i] & ena_q[i] & (src_pri[i] > cpu_mask) & ~insvc_q[i];
        end
    end

    irq_arbiter #(.N(MAX_IRQS)) u_arbiter (
        .elig    (elig),
        .src_pri (src_pri),
        .valid   (arb_valid),
        .index   (arb_idx),
        .pri     (arb_pri)
    );

    // Request FSM: latch a winner in IDLE, hold it frozen until ack or loss of eligibility.
    always_comb begin
        state_d   = state_q;
        req_d     = irq_req;
        vec_d     = irq_vector;
        pri_out_d = irq_pri;
        lat_idx_d = lat_idx_q;
        ack_set   = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d   = REQUEST;
                    req_d     = 1'b1;
                    lat_idx_d = arb_idx;
                    vec_d     = VECTOR_BASE + 8'(arb_idx);
                    pri_out_d = arb_pri;
                end
            end
            REQUEST: begin
                if (irq_ack) begin
                    ack_set[lat_idx_q] = 1'b1;
                    state_d            = IDLE;
                    req_d              = 1'b0;
                end else if (!elig[lat_idx_q]) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q      <= '0;
            ena_q      <= '0;
            flag_q     <= '0;
            insvc_q    <= '0;
            state_q    <= IDLE;
            lat_idx_q  <= '0;
            irq_req    <= 1'b0;
            irq_vector <= '0;
            irq_pri    <= '0;
        end else if (clk_ce_cpu) begin
            pri_q      <= pri_d;
            ena_q      <= ena_d;
            flag_q     <= flag_d;
            insvc_q    <= insvc_d;
            state_q    <= state_d;
            lat_idx_q  <= lat_idx_d;
            irq_req    <= req_d;
            irq_vector <= vec_d;
            irq_pri    <= pri_out_d;
        end
    end

endmodule
